// File: rtl/dma_req_sched_pkg.sv
// dma_req_sched_pkg: shared types and constants for the DMA request scheduler.
//   state_e         scheduler FSM encoding
//   CH_IDX_W        width of a channel index
//   TIMEOUT_DEFAULT default WAIT cycle budget before abort
package dma_req_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned CH_IDX_W        = 3;
  localparam int unsigned TIMEOUT_DEFAULT = 32'h0000_FFFF;

endpackage

// File: rtl/dma_req_sched_rr_pick.sv
// rr_pick: combinational round-robin search.  Returns the first set request
// starting at ptr_i and wrapping modulo N_CH.
//   req_i   [N_CH]      level requests
//   ptr_i   [CH_IDX_W]  search start (must be < N_CH)
//   valid_o             any request set
//   idx_o   [CH_IDX_W]  index of the selected request
module rr_pick
  import dma_req_sched_pkg::*;
#(
  parameter int unsigned N_CH = 5
) (
  input  logic [N_CH-1:0]     req_i,
  input  logic [CH_IDX_W-1:0] ptr_i,
  output logic                valid_o,
  output logic [CH_IDX_W-1:0] idx_o
);

  // Padding to the full index range keeps every lookup in bounds for any N_CH.
  logic [2**CH_IDX_W-1:0] req_pad;
  logic [CH_IDX_W:0]      cand;

  always_comb begin
    req_pad              = '0;
    req_pad[N_CH-1:0]    = req_i;
    valid_o              = 1'b0;
    idx_o                = '0;
    cand                 = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      // ptr_i < N_CH, so a single subtraction completes the modulo.
      cand = {1'b0, ptr_i} + (CH_IDX_W+1)'(i);
      if (cand >= (CH_IDX_W+1)'(N_CH)) begin
        cand = cand - (CH_IDX_W+1)'(N_CH);
      end
      if (!valid_o && req_pad[cand[CH_IDX_W-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = cand[CH_IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/dma_req_sched.sv
// dma_req_sched: round-robin scheduler sharing the DMA engine's request/ack
// channels.  Grants one requester, pulses dma_req_o for one cycle, waits for
// the matching dma_ack_i, measures latency and aborts after TIMEOUT cycles.
//   wb_clk_i, wb_rst_n_i   clock, async active-low reset
//   en_i                   enable, sampled in IDLE only
//   req_i      [N_CH]      level requests
//   gnt_o      [N_CH]      one-hot grant, held ISSUE..DONE
//   dma_req_o  [N_CH]      one-cycle request pulse
//   dma_ack_i  [N_CH]      DMA acknowledge
//   busy_o                 not IDLE
//   cur_ch_o   [3]         granted channel (last grant while IDLE)
//   done_o / timeout_o     one-cycle close pulses (ack / abort)
//   last_cnt_o [CNT_W]     latency of the last closed transfer
// Optional macro DMA_REQ_SCHED_STATS_EN adds per-channel completion/timeout
// counters readable via stat_sel_i [3] -> stat_o [24] (1-cycle latency).
module dma_req_sched
  import dma_req_sched_pkg::*;
#(
  parameter int unsigned N_CH    = 5,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  input  logic                en_i,
  input  logic [N_CH-1:0]     req_i,
  output logic [N_CH-1:0]     gnt_o,
  output logic [N_CH-1:0]     dma_req_o,
  input  logic [N_CH-1:0]     dma_ack_i,
  output logic                busy_o,
  output logic [CH_IDX_W-1:0] cur_ch_o,
  output logic                done_o,
  output logic                timeout_o,
  output logic [CNT_W-1:0]    last_cnt_o
`ifdef DMA_REQ_SCHED_STATS_EN
  ,
  input  logic [2:0]          stat_sel_i,
  output logic [23:0]         stat_o
`endif
);

  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT - 1);

  state_e                state_q;
  logic [CH_IDX_W-1:0]   rr_ptr_q;
  logic [CNT_W-1:0]      cyc_cnt_q;
  logic [N_CH-1:0]       gnt_q;
  logic [N_CH-1:0]       dma_req_q;
  logic [CH_IDX_W-1:0]   cur_ch_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  tmo_q;
  logic [CNT_W-1:0]      last_cnt_q;

  logic                  pick_valid;
  logic [CH_IDX_W-1:0]   pick_idx;
  logic [N_CH-1:0]       pick_oh;
  logic [2**CH_IDX_W-1:0] ack_pad;
  logic                  ack_sel;
  logic [CNT_W-1:0]      cnt_inc;
  logic [CH_IDX_W-1:0]   next_ptr;

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req_i   (req_i),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    pick_oh = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      pick_oh[i] = (pick_idx == CH_IDX_W'(i));
    end
    ack_pad           = '0;
    ack_pad[N_CH-1:0] = dma_ack_i;
    // Only the granted channel's ack is looked at; others are never latched.
    ack_sel  = ack_pad[cur_ch_q];
    // cyc_cnt is 0 during ISSUE, so cnt_inc is also the closing latency.
    cnt_inc  = (cyc_cnt_q == '1) ? cyc_cnt_q : cyc_cnt_q + 1'b1;
    next_ptr = (cur_ch_q == CH_IDX_W'(N_CH - 1)) ? '0 : cur_ch_q + 1'b1;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      cyc_cnt_q  <= '0;
      gnt_q      <= '0;
      dma_req_q  <= '0;
      cur_ch_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
      last_cnt_q <= '0;
    end else begin
      dma_req_q <= '0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (en_i && pick_valid) begin
            gnt_q     <= pick_oh;
            dma_req_q <= pick_oh;
            cur_ch_q  <= pick_idx;
            cyc_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          cyc_cnt_q <= cnt_inc;
          if (ack_sel) begin
            done_q     <= 1'b1;
            last_cnt_q <= cnt_inc;
            state_q    <= DONE;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cyc_cnt_q <= cnt_inc;
          // Ack is tested first so it wins over a coincident timeout.
          if (ack_sel) begin
            done_q     <= 1'b1;
            last_cnt_q <= cnt_inc;
            state_q    <= DONE;
          end else if (cyc_cnt_q >= TMO_LIMIT) begin
            tmo_q      <= 1'b1;
            last_cnt_q <= cnt_inc;
            state_q    <= DONE;
          end
        end
        DONE: begin
          gnt_q    <= '0;
          busy_q   <= 1'b0;
          rr_ptr_q <= next_ptr;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_o      = gnt_q;
  assign dma_req_o  = dma_req_q;
  assign busy_o     = busy_q;
  assign cur_ch_o   = cur_ch_q;
  assign done_o     = done_q;
  assign timeout_o  = tmo_q;
  assign last_cnt_o = last_cnt_q;

`ifdef DMA_REQ_SCHED_STATS_EN
  logic [15:0] cmp_cnt_q [N_CH];
  logic [7:0]  tmo_cnt_q [N_CH];
  logic [23:0] stat_q;
  logic [23:0] stat_d;

  always_comb begin
    stat_d = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (stat_sel_i == 3'(i)) begin
        stat_d = {tmo_cnt_q[i], cmp_cnt_q[i]};
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        cmp_cnt_q[i] <= '0;
        tmo_cnt_q[i] <= '0;
      end
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
      if (state_q == DONE) begin
        for (int unsigned i = 0; i < N_CH; i++) begin
          if (cur_ch_q == CH_IDX_W'(i)) begin
            if (done_q && cmp_cnt_q[i] != '1) cmp_cnt_q[i] <= cmp_cnt_q[i] + 1'b1;
            if (tmo_q && tmo_cnt_q[i] != '1) tmo_cnt_q[i] <= tmo_cnt_q[i] + 1'b1;
          end
        end
      end
    end
  end

  assign stat_o = stat_q;
`endif

endmodule

// File: tb/tb_dma_req_sched.sv
// tb_dma_req_sched: directed scoreboard bench for dma_req_sched (TIMEOUT=8).
// Stimulus pushes expected grants and closes into queues; a negedge monitor
// pops and compares whenever the DUT presents a grant or a close pulse.
module tb_dma_req_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [4:0] req;
  logic [4:0] gnt;
  logic [4:0] dma_req;
  logic [4:0] ack_resp = '0;
  logic [4:0] ack_spur = '0;
  logic [4:0] dma_ack;
  logic       busy;
  logic [2:0] cur_ch;
  logic       done;
  logic       tmo;
  logic [15:0] last_cnt;
`ifdef DMA_REQ_SCHED_STATS_EN
  logic [2:0]  stat_sel = '0;
  logic [23:0] stat;
`endif

  assign dma_ack = ack_resp | ack_spur;

  always #5 clk = ~clk;

  dma_req_sched #(.N_CH(5), .CNT_W(16), .TIMEOUT(8)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .en_i       (en),
    .req_i      (req),
    .gnt_o      (gnt),
    .dma_req_o  (dma_req),
    .dma_ack_i  (dma_ack),
    .busy_o     (busy),
    .cur_ch_o   (cur_ch),
    .done_o     (done),
    .timeout_o  (tmo),
    .last_cnt_o (last_cnt)
`ifdef DMA_REQ_SCHED_STATS_EN
    ,
    .stat_sel_i (stat_sel),
    .stat_o     (stat)
`endif
  );

  typedef struct {
    int ch;
    bit tmo;
    int last;
  } cls_t;

  int   checks = 0;
  int   errors = 0;
  int   exp_gnt[$];
  cls_t exp_cls[$];
  int   ack_dly = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] oh(input int ch);
    logic [4:0] one;
    one = 5'd1;
    return one << ch;
  endfunction

  // Monitor: compares every grant and every close against the queues.
  always @(negedge clk) begin
    if (dma_req != '0) begin
      if (exp_gnt.size() == 0) begin
        chk("unexpected_grant", 32'(dma_req), 32'd0);
      end else begin
        int ch;
        ch = exp_gnt.pop_front();
        chk("grant_dma_req", 32'(dma_req), 32'(oh(ch)));
        chk("grant_gnt",     32'(gnt),     32'(oh(ch)));
        chk("grant_cur_ch",  32'(cur_ch),  32'(ch));
        chk("grant_busy",    32'(busy),    32'd1);
      end
    end
    if (done || tmo) begin
      if (exp_cls.size() == 0) begin
        chk("unexpected_close", {30'd0, done, tmo}, 32'd0);
      end else begin
        cls_t e;
        e = exp_cls.pop_front();
        chk("close_done",     32'(done),     32'(!e.tmo));
        chk("close_timeout",  32'(tmo),      32'(e.tmo));
        chk("close_last_cnt", 32'(last_cnt), 32'(e.last));
        chk("close_cur_ch",   32'(cur_ch),   32'(e.ch));
        chk("close_gnt",      32'(gnt),      32'(oh(e.ch)));
        chk("close_dma_req",  32'(dma_req),  32'd0);
      end
    end
  end

  // Responder: acks the requested channel ack_dly negedges after the request
  // is seen (0 = during ISSUE), for one cycle; negative = never.
  initial begin
    forever begin
      @(negedge clk);
      if (dma_req != '0 && ack_dly >= 0) begin
        logic [4:0] ch_oh;
        ch_oh = dma_req;
        repeat (ack_dly) @(negedge clk);
        ack_resp = ch_oh;
        @(negedge clk);
        ack_resp = '0;
      end
    end
  end

  task automatic wait_grant();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (dma_req == '0 && n < 60);
    if (dma_req == '0) chk("grant_wait_expired", 32'd1, 32'd0);
  endtask

  task automatic wait_close();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(done || tmo) && n < 60);
    if (!(done || tmo)) chk("close_wait_expired", 32'd1, 32'd0);
  endtask

  // One transfer: request vector, expected channel, ack delay, expected close.
  task automatic xfer(input logic [4:0] rv, input int ch, input int dly,
                      input bit etmo, input int elast, input int spur);
    cls_t c;
    ack_dly = dly;
    c.ch = ch; c.tmo = etmo; c.last = elast;
    exp_gnt.push_back(ch);
    exp_cls.push_back(c);
    req = rv;
    wait_grant();
    req = '0;
    if (spur >= 0) begin
      @(negedge clk);
      ack_spur = oh(spur);
      @(negedge clk);
      ack_spur = '0;
    end
    wait_close();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    req   = '0;
    #2;
    chk("rst_gnt",      32'(gnt),      32'd0);
    chk("rst_dma_req",  32'(dma_req),  32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_cur_ch",   32'(cur_ch),   32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_timeout",  32'(tmo),      32'd0);
    chk("rst_last_cnt", 32'(last_cnt), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fairness: all requesting, ack one cycle after each request.
    ack_dly = 1;
    for (int g = 0; g < 6; g++) begin
      cls_t c;
      c.ch = g % 5; c.tmo = 1'b0; c.last = 2;
      exp_gnt.push_back(g % 5);
      exp_cls.push_back(c);
    end
    req = 5'b11111;
    for (int g = 0; g < 6; g++) begin
      wait_grant();
      if (g == 5) req = '0;
      wait_close();
    end

    // Single channel, ack seen at the third edge after the request edge.
    xfer(5'b00100, 2, 2, 1'b0, 3, -1);
    // Timeout with no ack, then ack during ISSUE on the next grant.
    xfer(5'b00010, 1, -1, 1'b1, 8, -1);
    xfer(5'b10000, 4, 0, 1'b0, 1, -1);
    // Spurious ack on ch3 while ch0 waits.
    xfer(5'b00001, 0, 4, 1'b0, 5, 3);
    // Ack on the timeout-limit cycle: completion wins.
    xfer(5'b00010, 1, 7, 1'b0, 8, -1);

    // Disabled: no grant for 20 cycles.
    en  = 1'b0;
    req = 5'b00001;
    repeat (20) @(negedge clk);
    chk("dis_busy", 32'(busy), 32'd0);
    chk("dis_gnt",  32'(gnt),  32'd0);
    en = 1'b1;
    xfer(5'b00001, 0, 3, 1'b0, 4, -1);

    // Async reset mid-WAIT.
    ack_dly = -1;
    exp_gnt.push_back(3);
    req = 5'b01000;
    wait_grant();
    req = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt",      32'(gnt),      32'd0);
    chk("arst_busy",     32'(busy),     32'd0);
    chk("arst_cur_ch",   32'(cur_ch),   32'd0);
    chk("arst_last_cnt", 32'(last_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // rr_ptr back at 0 picks ch0 over ch4.
    xfer(5'b10001, 0, 1, 1'b0, 2, -1);

`ifdef DMA_REQ_SCHED_STATS_EN
    for (int k = 0; k < 3; k++) xfer(5'b10000, 4, 1, 1'b0, 2, -1);
    xfer(5'b10000, 4, -1, 1'b1, 8, -1);
    stat_sel = 3'd4;
    repeat (2) @(negedge clk);
    chk("stat_ch4", 32'(stat), 32'h0001_0003);
    stat_sel = 3'd5;
    repeat (2) @(negedge clk);
    chk("stat_oob", 32'(stat), 32'd0);
`endif

    repeat (5) @(negedge clk);
    chk("gnt_queue_left", 32'(exp_gnt.size()), 32'd0);
    chk("cls_queue_left", 32'(exp_cls.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
